// File: rtl/pipe_ctrl.sv
// Multi-stage valid/data pipeline with a counted multi-edge stall and a partial flush.
// All state advances on the falling clock edge; flush always wins over stall.
module pipe_ctrl #(
  parameter int STAGES     = 5,
  parameter int WIDTH      = 32,
  parameter int HOLD_STAGE = 4,
  parameter int LEN_W      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic                      stall_req,
  input  logic [LEN_W-1:0]          stall_len,
  input  logic                      flush_req,
  input  logic [$clog2(STAGES)-1:0] flush_stage,
  output logic [STAGES-1:0]         stage_valid,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      stall_active,
  output logic [7:0]                flush_cnt
);

  localparam int FW = $clog2(STAGES);

  typedef enum logic {RUN, STALL} mode_e;

  mode_e             mode;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        flushCnt_q, flushCnt_d;
  logic [FW-1:0]     flushSel;

  // Array index k holds stage k+1, so index 0 is the youngest stage.
  always_comb begin
    mode     = (stall_req || (cnt_q != '0)) ? STALL : RUN;
    in_ready = ~flush_req & (mode == RUN);

    if (flush_stage > FW'(STAGES - 1)) begin
      flushSel = FW'(STAGES - 1);
    end else if (flush_stage == '0) begin
      flushSel = FW'(1);
    end else begin
      flushSel = flush_stage;
    end

    valid_d[0] = in_valid;
    data_d[0]  = in_valid ? in_data : '0;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      data_d[k]  = data_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      if (flush_req) begin
        if (k <= int'(flushSel)) begin
          valid_d[k] = 1'b0;
          data_d[k]  = '0;
        end
      end else if (mode == STALL) begin
        if (k < HOLD_STAGE) begin
          valid_d[k] = valid_q[k];
          data_d[k]  = data_q[k];
        end else if (k == HOLD_STAGE) begin
          valid_d[k] = 1'b0;
          data_d[k]  = '0;
        end
      end
    end

    // A new request only starts from an idle counter; the current edge is the first hold edge.
    if (flush_req) begin
      cnt_d = '0;
    end else if (stall_req && (cnt_q == '0)) begin
      cnt_d = (stall_len == '0) ? '0 : stall_len - LEN_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LEN_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    flushCnt_d = (flush_req && (flushCnt_q != 8'hFF)) ? flushCnt_q + 8'd1 : flushCnt_q;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      cnt_q      <= '0;
      flushCnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      flushCnt_q <= flushCnt_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign stage_valid  = valid_q;
  assign out_valid    = valid_q[STAGES-1];
  assign out_data     = data_q[STAGES-1];
  assign stall_active = (cnt_q != '0);
  assign flush_cnt    = flushCnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (STAGES=5, WIDTH=32, HOLD_STAGE=4): directed
// scenarios plus a randomized run compared against a stage-array reference model.
module tb_pipe_ctrl;

  localparam int S = 5;
  localparam int H = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        stall_req;
  logic [3:0]  stall_len;
  logic        flush_req;
  logic [2:0]  flush_stage;
  logic [4:0]  stage_valid;
  logic        out_valid;
  logic [31:0] out_data;
  logic        stall_active;
  logic [7:0]  flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: one valid bit and payload per stage number, plus hold edges still owed.
  bit          mv [1:S];
  logic [31:0] md [1:S];
  int          mHold;
  int          mFlush;
  bit          obsReady;
  bit          expReady;

  pipe_ctrl #(.STAGES(5), .WIDTH(32), .HOLD_STAGE(4), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_req(stall_req), .stall_len(stall_len), .flush_req(flush_req),
    .flush_stage(flush_stage), .stage_valid(stage_valid), .out_valid(out_valid),
    .out_data(out_data), .stall_active(stall_active), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    for (int k = 1; k <= S; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
    mHold  = 0;
    mFlush = 0;
  endtask

  task automatic modelEdge(input bit v, input logic [31:0] d, input bit sr, input int sl,
                           input bit fr, input int fs);
    bit          nv [1:S];
    logic [31:0] nd [1:S];
    bit          hold;
    int          f;
    hold = sr || (mHold > 0);
    nv[1] = v;
    nd[1] = v ? d : 32'h0;
    for (int k = 2; k <= S; k++) begin
      nv[k] = mv[k-1];
      nd[k] = md[k-1];
    end
    if (fr) begin
      f = (fs > S - 1) ? S - 1 : ((fs < 1) ? 1 : fs);
      for (int k = 1; k <= f + 1; k++) begin
        nv[k] = 1'b0;
        nd[k] = 32'h0;
      end
      mHold = 0;
    end else if (hold) begin
      for (int k = 1; k <= H; k++) begin
        nv[k] = mv[k];
        nd[k] = md[k];
      end
      nv[H+1] = 1'b0;
      nd[H+1] = 32'h0;
      if (mHold == 0) mHold = (sl < 1) ? 0 : sl - 1;
      else mHold = mHold - 1;
    end
    if (fr && mFlush < 255) mFlush = mFlush + 1;
    for (int k = 1; k <= S; k++) begin
      mv[k] = nv[k];
      md[k] = nd[k];
    end
  endtask

  function automatic logic [4:0] packValid();
    logic [4:0] p;
    for (int k = 1; k <= S; k++) p[k-1] = mv[k];
    return p;
  endfunction

  // Drive one cycle of inputs, capture in_ready before the edge, then advance model and DUT.
  task automatic applyStimulus(input bit v, input logic [31:0] d, input bit sr, input int sl,
                               input bit fr, input int fs);
    int slm;
    int fsm;
    slm = sl & 15;
    fsm = fs & 7;
    in_valid    = v;
    in_data     = d;
    stall_req   = sr;
    stall_len   = slm[3:0];
    flush_req   = fr;
    flush_stage = fsm[2:0];
    #1;
    obsReady = in_ready;
    expReady = !fr && !(sr || (mHold > 0));
    @(negedge clk);
    modelEdge(v, d, sr, slm, fr, fsm);
    #1;
  endtask

  task automatic loadWords(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, base + 32'(i), 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; stall_req = 1'b0; stall_len = '0;
    flush_req = 1'b0; flush_stage = '0;
    modelReset();
    #2;
    checks++; if (stage_valid !== 5'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 00000", stage_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_data: got %h expected 0", out_data); end
    checks++; if (stall_active !== 1'b0 || flush_cnt !== 8'h0) begin errors++; $display("[TB] FAIL rst_cnt: got %b/%0d expected 0/0", stall_active, flush_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready_idle: got %b expected 1", in_ready); end
    stall_req = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready_stall: got %b expected 0", in_ready); end
    stall_req = 1'b0; flush_req = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready_flush: got %b expected 0", in_ready); end
    flush_req = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    checks++; if (stage_valid !== 5'b0) begin errors++; $display("[TB] FAIL rst_no_load: got %b expected 00000", stage_valid); end
    in_valid = 1'b0; in_data = '0;
    @(negedge clk); #3;
    reset = 1'b1;
  endtask

  task automatic test_latency();
    logic [4:0] expSv;
    for (int n = 1; n <= 6; n++) begin
      applyStimulus(n == 1, 32'h11, 1'b0, 0, 1'b0, 0);
      expSv = '0;
      if (n <= 5) expSv[n-1] = 1'b1;
      checks++; if (stage_valid !== expSv) begin errors++; $display("[TB] FAIL lat_valid[%0d]: got %b expected %b", n, stage_valid, expSv); end
      checks++; if (out_valid !== (n == 5)) begin errors++; $display("[TB] FAIL lat_outv[%0d]: got %b expected %b", n, out_valid, n == 5); end
      checks++; if (out_data !== ((n == 5) ? 32'h11 : 32'h0)) begin errors++; $display("[TB] FAIL lat_data[%0d]: got %h", n, out_data); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] expOut [5];
    int readyLow;
    int activeHigh;
    expOut = '{32'h0, 32'h0, 32'h0, 32'hD000_0001, 32'hD000_0002};
    readyLow = 0;
    activeHigh = 0;
    loadWords(32'hD000_0000, 5);
    checks++; if (out_data !== 32'hD000_0000) begin errors++; $display("[TB] FAIL stall_pre: got %h expected d0000000", out_data); end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'hBAD0_0000 + 32'(i), i == 0, 3, 1'b0, 0);
      if (!obsReady) readyLow++;
      if (stall_active) activeHigh++;
      checks++; if (out_data !== expOut[i]) begin errors++; $display("[TB] FAIL stall_out[%0d]: got %h expected %h", i, out_data, expOut[i]); end
      if (i == 0) begin
        checks++; if (stage_valid !== 5'b01111) begin errors++; $display("[TB] FAIL stall_bubble: got %b expected 01111", stage_valid); end
      end
    end
    checks++; if (readyLow != 3) begin errors++; $display("[TB] FAIL stall_ready_edges: got %0d expected 3", readyLow); end
    checks++; if (activeHigh != 2) begin errors++; $display("[TB] FAIL stall_active_edges: got %0d expected 2", activeHigh); end
  endtask

  task automatic test_flush();
    loadWords(32'hF000_0001, 5);
    applyStimulus(1'b1, 32'hBEEF, 1'b0, 0, 1'b1, 2);
    checks++; if (obsReady !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready: got %b expected 0", obsReady); end
    checks++; if (stage_valid !== 5'b11000) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 11000", stage_valid); end
    checks++; if (out_data !== 32'hF000_0002) begin errors++; $display("[TB] FAIL flush_out: got %h expected f0000002", out_data); end
    checks++; if (flush_cnt !== 8'd1) begin errors++; $display("[TB] FAIL flush_cnt1: got %0d expected 1", flush_cnt); end
    applyStimulus(1'b0, 32'h0, 1'b0, 0, 1'b0, 0);
    checks++; if (out_data !== 32'hF000_0003 || stage_valid !== 5'b10000) begin errors++; $display("[TB] FAIL flush_next: got %h/%b expected f0000003/10000", out_data, stage_valid); end
  endtask

  task automatic test_flush_over_stall();
    loadWords(32'hE000_0001, 5);
    applyStimulus(1'b0, 32'h0, 1'b1, 5, 1'b1, 1);
    checks++; if (stall_active !== 1'b0) begin errors++; $display("[TB] FAIL fos_active: got %b expected 0", stall_active); end
    checks++; if (stage_valid !== 5'b11100) begin errors++; $display("[TB] FAIL fos_valid: got %b expected 11100", stage_valid); end
    checks++; if (flush_cnt !== 8'd2) begin errors++; $display("[TB] FAIL fos_cnt: got %0d expected 2", flush_cnt); end
    applyStimulus(1'b0, 32'h0, 1'b0, 0, 1'b0, 0);
    checks++; if (obsReady !== 1'b1) begin errors++; $display("[TB] FAIL fos_ready: got %b expected 1", obsReady); end
  endtask

  task automatic test_stall_zero_and_sat();
    loadWords(32'hC000_0001, 5);
    applyStimulus(1'b0, 32'h0, 1'b1, 0, 1'b0, 0);
    checks++; if (obsReady !== 1'b0) begin errors++; $display("[TB] FAIL sz_ready0: got %b expected 0", obsReady); end
    checks++; if (stall_active !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sz_hold: got %b/%b expected 0/0", stall_active, out_valid); end
    applyStimulus(1'b0, 32'h0, 1'b0, 0, 1'b0, 0);
    checks++; if (obsReady !== 1'b1) begin errors++; $display("[TB] FAIL sz_ready1: got %b expected 1", obsReady); end
    checks++; if (out_data !== 32'hC000_0002 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sz_resume: got %h/%b expected c0000002/1", out_data, out_valid); end
    for (int i = 1; i <= 260; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 0, 1'b1, $urandom_range(0, 7));
      if (i == 252) begin
        checks++; if (flush_cnt !== 8'd254) begin errors++; $display("[TB] FAIL sat_254: got %0d expected 254", flush_cnt); end
      end
      if (i == 253) begin
        checks++; if (flush_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_255: got %0d expected 255", flush_cnt); end
      end
    end
    checks++; if (flush_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 255", flush_cnt); end
  endtask

  task automatic test_async_reset();
    loadWords(32'hA5A5_0000, 5);
    applyStimulus(1'b0, 32'h0, 1'b1, 8, 1'b0, 0);
    checks++; if (stall_active !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre: got %b expected 1", stall_active); end
    stall_req = 1'b0;
    #3 reset = 1'b0;
    #1;
    checks++; if (stage_valid !== 5'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_valid: got %b expected 00000", stage_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL ar_data: got %h expected 0", out_data); end
    checks++; if (stall_active !== 1'b0 || flush_cnt !== 8'h0) begin errors++; $display("[TB] FAIL ar_cnt: got %b/%0d expected 0/0", stall_active, flush_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ar_ready: got %b expected 1", in_ready); end
    modelReset();
    @(negedge clk); #3;
    reset = 1'b1;
    applyStimulus(1'b1, 32'h5A, 1'b0, 0, 1'b0, 0);
    checks++; if (stage_valid !== 5'b00001 || stall_active !== 1'b0) begin errors++; $display("[TB] FAIL ar_restart: got %b/%b expected 00001/0", stage_valid, stall_active); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 6), $urandom_range(0, 19) == 0, $urandom_range(0, 7));
      checks++; if (obsReady !== expReady) begin errors++; $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", i, obsReady, expReady); end
      checks++; if (stage_valid !== packValid()) begin errors++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", i, stage_valid, packValid()); end
      checks++; if (out_valid !== mv[S] || out_data !== md[S]) begin errors++; $display("[TB] FAIL rnd_out[%0d]: got %b/%h expected %b/%h", i, out_valid, out_data, mv[S], md[S]); end
      checks++; if (stall_active !== (mHold > 0)) begin errors++; $display("[TB] FAIL rnd_active[%0d]: got %b expected %b", i, stall_active, mHold > 0); end
      checks++; if (flush_cnt !== 8'(mFlush)) begin errors++; $display("[TB] FAIL rnd_fcnt[%0d]: got %0d expected %0d", i, flush_cnt, mFlush); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_flush_over_stall();
    test_stall_zero_and_sat();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
